adder_serial_controller: RTL

Bit-serial N-bit adder controller that sequences one 1-bit full-add slice over WIDTH clock cycles. It trades latency for area in low-gate-count paths. It accepts two operands on a start pulse, processes them LSB first with a registered carry, and presents a held sum/carry with a one-cycle done strobe. It sits between a requesting control block and the shared 1-bit adder datapath.

---
 rtl/adder_serial_controller_pkg.sv | 17 +
 rtl/adder_serial_controller_slice.sv | 39 +++
 rtl/adder_serial_controller.sv | 112 +++++++++++
 3 files changed

// File: rtl/adder_serial_controller_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Optional subtract support is enabled by ADDER_SERIAL_SUBTRACT_EN.
package adder_serial_controller_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_RUN  = 2'd1,
        STATE_DONE = 2'd2
    } state_t;

    // Bit counter width: ceil(log2(w)), never below one bit.
    function automatic int cnt_width(input int w);
        if (w <= 2) return 1;
        return $clog2(w);
    endfunction

endpackage

// File: rtl/adder_serial_controller_slice.sv
// One-bit full-add slice built from two half adders.
// The controller time-shares a single instance across all bit positions.
module adder_half_1bit (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

module adder_full_1bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    logic w_s0;
    logic w_c0;
    logic w_c1;

    adder_half_1bit u_ha0 (
        .i_a (i_a),
        .i_b (i_b),
        .o_s (w_s0),
        .o_c (w_c0)
    );

    adder_half_1bit u_ha1 (
        .i_a (w_s0),
        .i_b (i_c),
        .o_s (o_s),
        .o_c (w_c1)
    );

    assign o_c = w_c0 | w_c1;
endmodule

// File: rtl/adder_serial_controller.sv
// Bit-serial adder controller: LSB-first, one slice, registered carry.
// Define ADDER_SERIAL_SUBTRACT_EN to add the sub port (a - b mode).
module adder_serial_controller
    import adder_serial_controller_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
`ifdef ADDER_SERIAL_SUBTRACT_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE = CW'(1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_b_load;
    logic             w_cin_load;
    logic             w_s;
    logic             w_co;

`ifdef ADDER_SERIAL_SUBTRACT_EN
    // Subtract as a + ~b + 1: invert b and seed the carry.
    assign w_b_load   = sub ? ~input_b : input_b;
    assign w_cin_load = sub;
`else
    assign w_b_load   = input_b;
    assign w_cin_load = 1'b0;
`endif

    adder_full_1bit u_slice (
        .i_a (r_a[0]),
        .i_b (r_b[0]),
        .i_c (r_cin),
        .o_s (w_s),
        .o_c (w_co)
    );

    // Sequencer: load on start, one bit per RUN cycle, strobe done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= STATE_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cin   <= 1'b0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                STATE_IDLE: begin
                    if (start) begin
                        r_a     <= input_a;
                        r_b     <= w_b_load;
                        r_cin   <= w_cin_load;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_carry <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= STATE_RUN;
                    end
                end
                STATE_RUN: begin
                    r_sum <= {w_s, r_sum[WIDTH-1:1]};
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_cin <= w_co;
                    r_cnt <= r_cnt + ONE;
                    if (r_cnt == LAST) begin
                        r_carry <= w_co;
                        r_done  <= 1'b1;
                        r_state <= STATE_DONE;
                    end
                end
                STATE_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= STATE_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= STATE_IDLE;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign sum   = r_sum;
    assign carry = r_carry;
endmodule
